// File: rtl/torrence_params.sv
// Shared types for the torrence cache: memory operations and cache controller states.
package torrence_params;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITEBACK = 3'd1,
        WB_DONE   = 3'd2,
        FETCH     = 3'd3,
        INSTALL   = 3'd4
    } cache_state_e;

endpackage

// File: rtl/cache_controller.sv
// Sequencing FSM for one cache instance: lookup, hit service, dirty-victim writeback,
// word-by-word line refill from the higher memory level, and line install.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lookup; a hit is serviced in the same cycle, a miss starts recovery
// WRITEBACK | dirty victim words streamed to higher memory (descending order)
// WB_DONE   | victim gone: invalidate way, re-latch request block address
// FETCH     | requested line streamed in from higher memory, word per transfer
// INSTALL   | mark new line valid; the request is replayed as a hit in IDLE
module cache_controller
    import torrence_params::*;
#(
    parameter bit READ_ONLY = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_valid,
    input  logic req_operation,
    output logic req_fulfilled,
    output logic hmem_valid,
    output logic hmem_operation,
    input  logic hmem_fulfilled,
    input  logic valid_block_match,
    input  logic valid_dirty_bit,
    input  logic counter_done,
    output logic miss_recovery_mode,
    output logic set_hmem_block_address,
    output logic use_victim_tag_for_hmem_block_address,
    output logic reset_counter,
    output logic decrement_counter,
    output logic perform_write,
    output logic process_lru_counters,
    output logic clear_selected_valid_bit,
    output logic set_selected_dirty_bit,
    output logic clear_selected_dirty_bit,
    output logic finish_new_line_install,
    output logic count_hit,
    output logic count_miss,
    output logic count_read,
    output logic count_write,
    output logic count_writeback
);

    cache_state_e state_q, state_d;
    logic         replay_q, replay_d;
    logic         is_store;

    // An I-cache never stores, so a STORE opcode is treated as a load there.
    assign is_store = (req_operation == STORE) && !READ_ONLY;

    // State and replay flag; the replay flag keeps the re-lookup after a refill
    // from being counted as a second (hit) event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            replay_q <= replay_d;
        end
    end

    // Next state and every datapath strobe; all strobes are forced low during reset.
    always_comb begin
        state_d                               = state_q;
        replay_d                              = replay_q;
        req_fulfilled                         = 1'b0;
        hmem_valid                            = 1'b0;
        hmem_operation                        = LOAD;
        miss_recovery_mode                    = 1'b0;
        set_hmem_block_address                = 1'b0;
        use_victim_tag_for_hmem_block_address = 1'b0;
        reset_counter                         = 1'b0;
        decrement_counter                     = 1'b0;
        perform_write                         = 1'b0;
        process_lru_counters                  = 1'b0;
        clear_selected_valid_bit              = 1'b0;
        set_selected_dirty_bit                = 1'b0;
        clear_selected_dirty_bit              = 1'b0;
        finish_new_line_install               = 1'b0;
        count_hit                             = 1'b0;
        count_miss                            = 1'b0;
        count_read                            = 1'b0;
        count_write                           = 1'b0;
        count_writeback                       = 1'b0;

        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (valid_block_match) begin
                            req_fulfilled        = 1'b1;
                            process_lru_counters = 1'b1;
                            perform_write        = is_store;
                            set_selected_dirty_bit = is_store;
                            count_write          = is_store;
                            count_read           = !is_store;
                            count_hit            = !replay_q;
                            replay_d             = 1'b0;
                        end else begin
                            count_miss             = 1'b1;
                            set_hmem_block_address = 1'b1;
                            reset_counter          = 1'b1;
                            if (valid_dirty_bit && !READ_ONLY) begin
                                use_victim_tag_for_hmem_block_address = 1'b1;
                                state_d = WRITEBACK;
                            end else begin
                                // Invalidate before refill so an aborted fill never
                                // leaves a partially written line marked valid.
                                clear_selected_valid_bit = 1'b1;
                                state_d = FETCH;
                            end
                        end
                    end
                end

                WRITEBACK: begin
                    miss_recovery_mode = 1'b1;
                    hmem_valid         = 1'b1;
                    hmem_operation     = STORE;
                    if (hmem_fulfilled) begin
                        if (counter_done) begin
                            count_writeback = 1'b1;
                            state_d         = WB_DONE;
                        end else begin
                            decrement_counter = 1'b1;
                        end
                    end
                end

                WB_DONE: begin
                    set_hmem_block_address   = 1'b1;
                    reset_counter            = 1'b1;
                    clear_selected_dirty_bit = 1'b1;
                    clear_selected_valid_bit = 1'b1;
                    state_d                  = FETCH;
                end

                FETCH: begin
                    miss_recovery_mode = 1'b1;
                    hmem_valid         = 1'b1;
                    hmem_operation     = LOAD;
                    if (hmem_fulfilled) begin
                        perform_write = 1'b1;
                        if (counter_done) begin
                            state_d = INSTALL;
                        end else begin
                            decrement_counter = 1'b1;
                        end
                    end
                end

                INSTALL: begin
                    finish_new_line_install = 1'b1;
                    replay_d                = 1'b1;
                    state_d                 = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
